move_scheduler: RTL
===================

# move_scheduler

Sequences one move-generation pass over a board held in SDRAM. It scans the 64 squares of a source board and, for every piece belonging to the side to move, programs and starts the matching per-piece generator (pawn, knight, …) over a shared generator bus. It then collects that generator's output-board count and packs all generated boards contiguously into a destination region. It sits between the CPU (Avalon-MM slave) and the piece-generator slaves, and has its own SDRAM read master for square fetches.

## Interface
Parameters:
- NUM_GEN, 6, number of piece generators; generator index = |piece| − 1
- BOARD_BYTES, 256, bytes per board (64 squares × 4 B); destination stride per generated board

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- slave_waitrequest  out  1  always 0
- slave_address  in  4  CPU register select
- slave_read / slave_write  in  1  CPU strobes
- slave_readdata  out  32  CPU read data, combinational from slave_address
- slave_writedata  in  32  CPU write data
- master_waitrequest  in  1  SDRAM stall
- master_address  out  32  SDRAM byte address
- master_read  out  1  SDRAM read strobe
- master_readdata  in  32  SDRAM data
- master_readdatavalid  in  1  SDRAM read response
- gen_waitrequest  in  1  generator stall (muxed from the selected generator)
- gen_address  out  8  [6:4] generator index, [3:0] generator register
- gen_write / gen_read  out  1  generator strobes
- gen_writedata  out  32  generator write data
- gen_readdata  in  32  generator read data, valid when gen_read && !gen_waitrequest

## Operation
CPU registers:
- Write 1: src_board_addr. Write 2: dest_base. Write 3: max_boards. All are ignored while busy.
- Write 0: start; writedata[0] = side (0 white, 1 black). Ignored while busy.
- Read 0: {busy[31], overflow[30], 14'b0, total[15:0]}.
- Read 1: dispatch count[15:0].

Pieces are signed 8-bit from readdata[7:0]: 0 empty, >0 white, <0 black. A piece is eligible if it is nonzero, its sign matches side, and 1 ≤ |pc| ≤ NUM_GEN.

States:
- IDLE: busy=0. On start: sq=0, total=0, dispatches=0, overflow=0, cur_dest=dest_base → RD_SQ.
- RD_SQ: master_read=1, address = src_board_addr + 4·sq. Hold until !master_waitrequest → WT_SQ.
- WT_SQ: wait for master_readdatavalid; latch pc → DECIDE.
- DECIDE: if eligible → WR_SRC; else → NEXT.
- WR_SRC, WR_DST, WR_X, WR_Y, WR_GO: one gen_write each, to registers 1, 2, 3, 4, 0 of generator |pc|−1. Data is respectively src_board_addr, cur_dest, sq[2:0] (x), sq[5:3] (y), and 0. Each state holds while gen_waitrequest. The last one → RD_CNT.
- RD_CNT: gen_read at register 0. Hold while gen_waitrequest (the generator stalls until it finishes). On acceptance: n = gen_readdata[15:0]; total += n; cur_dest += n·BOARD_BYTES; dispatches++ → CHK.
- CHK: if total ≥ max_boards → overflow=1, DONE; else → NEXT.
- NEXT: if sq==63 → DONE; else sq++ → RD_SQ.
- DONE: busy=0, results held → IDLE. Registers stay readable until the next start.

Rules:
- Only one bus transaction is outstanding at a time. gen_* and master_* are never active in the same cycle.
- Arithmetic: sq is 6 bits; total and dispatches are 16 bits and saturate at 0xFFFF. cur_dest is 32 bits and wraps modulo 2^32.
- When not driven, strobes are 0 and addresses/data are 0.
- max_boards = 0: the first eligible dispatch completes, then overflow sets.
- n = 0: no advance; scanning continues.
- Reset mid-pass: all state returns to IDLE next cycle and strobes drop immediately. In-flight SDRAM responses after reset are ignored.

## Timing
- Reset values: slave_waitrequest=0, master_read=0, master_address=0, gen_read=0, gen_write=0, gen_address=0, gen_writedata=0, busy=0, overflow=0, total=0, dispatches=0. Config registers = 0.
- Start → first master_read: 1 cycle (busy visible the cycle after the write).
- Empty square with zero-wait SDRAM and 1-cycle readdatavalid: RD_SQ, WT_SQ, DECIDE, NEXT = 4 cycles.
- Dispatch overhead with zero waits: 5 writes + 1 read + CHK + NEXT = 8 cycles plus generator run time.
- Empty board, zero wait: 64×4 + 1 ≈ 257 cycles to busy=0.

## Test plan
- Empty board, side=0, max=100 → 64 SDRAM reads at src+0..src+252 step 4, no gen traffic, status = 0x00000000.
- White pawn at sq 12 (x=4, y=1); model generator returns 2 → gen writes to 0x01,0x02,0x03(4),0x04(1),0x00; cur_dest = dest+512; total=2; dispatches=1.
- Black pieces −1 at sq 48 and −2 at sq 57, side=1, generators return 1 and 3 → dispatches to indices 0 then 1; second dest write = dest+256; total=4.
- Same board, side=0 → no dispatch; white-only pieces and piece value 7 are skipped.
- max_boards=3, four eligible pawns, each generator returns 2 → stops after the 2nd dispatch; status = busy 0, overflow 1, total 4.
- Assert rst during a stalled RD_CNT (gen_waitrequest=1) → gen_read=0 next cycle, status 0; a new start runs normally.

Source files
------------

// File: rtl/move_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module   : move_scheduler_if
//  Brief    : Bus bundle for the move scheduler: CPU register slave, SDRAM
//             read master and shared piece-generator bus.
//             'master' is the scheduler's view, 'slave' is the system side
//             (CPU, SDRAM and generators).
//  Revision : 1.0  initial release
// ============================================================================
interface move_scheduler_if;
    // CPU register slave
    logic        slave_waitrequest;
    logic [3:0]  slave_address;
    logic        slave_read;
    logic        slave_write;
    logic [31:0] slave_readdata;
    logic [31:0] slave_writedata;
    // SDRAM read master
    logic        master_waitrequest;
    logic [31:0] master_address;
    logic        master_read;
    logic [31:0] master_readdata;
    logic        master_readdatavalid;
    // Generator bus
    logic        gen_waitrequest;
    logic [7:0]  gen_address;
    logic        gen_write;
    logic        gen_read;
    logic [31:0] gen_writedata;
    logic [31:0] gen_readdata;

    modport master (
        output slave_waitrequest, slave_readdata,
        input  slave_address, slave_read, slave_write, slave_writedata,
        output master_address, master_read,
        input  master_waitrequest, master_readdata, master_readdatavalid,
        output gen_address, gen_write, gen_read, gen_writedata,
        input  gen_waitrequest, gen_readdata
    );

    modport slave (
        input  slave_waitrequest, slave_readdata,
        output slave_address, slave_read, slave_write, slave_writedata,
        input  master_address, master_read,
        output master_waitrequest, master_readdata, master_readdatavalid,
        input  gen_address, gen_write, gen_read, gen_writedata,
        output gen_waitrequest, gen_readdata
    );
endinterface
`default_nettype wire

// File: rtl/move_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : move_scheduler
//  Brief    : Scans the 64 squares of a board in SDRAM and, for each piece of
//             the side to move, programs and runs the matching generator,
//             packing the produced boards contiguously at the destination.
//  Revision : 1.0  initial release
// ============================================================================
module move_scheduler #(
    parameter int NUM_GEN     = 6,
    parameter int BOARD_BYTES = 256
) (
    input  wire logic         clk,
    input  wire logic         rst,
    move_scheduler_if.master  bus
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_RD_SQ  = 4'd1;
    localparam logic [3:0] S_WT_SQ  = 4'd2;
    localparam logic [3:0] S_DECIDE = 4'd3;
    localparam logic [3:0] S_WR_SRC = 4'd4;
    localparam logic [3:0] S_WR_DST = 4'd5;
    localparam logic [3:0] S_WR_X   = 4'd6;
    localparam logic [3:0] S_WR_Y   = 4'd7;
    localparam logic [3:0] S_WR_GO  = 4'd8;
    localparam logic [3:0] S_RD_CNT = 4'd9;
    localparam logic [3:0] S_CHK    = 4'd10;
    localparam logic [3:0] S_NEXT   = 4'd11;
    localparam logic [3:0] S_DONE   = 4'd12;

    localparam logic [7:0]  c_NUM_GEN     = 8'(NUM_GEN);
    localparam logic [31:0] c_BOARD_BYTES = 32'(BOARD_BYTES);

    logic [3:0]  r_state;
    logic [31:0] r_src;
    logic [31:0] r_dest_base;
    logic [31:0] r_max;
    logic        r_side;
    logic [5:0]  r_sq;
    logic [7:0]  r_pc;
    logic [15:0] r_total;
    logic [15:0] r_disp;
    logic        r_ovf;
    logic [31:0] r_cur_dest;

    logic [3:0]  w_nxt;
    logic [5:0]  w_sq_nxt;
    logic        w_busy;
    logic        w_start;
    logic [7:0]  w_abs;
    logic [7:0]  w_absm1;
    logic [2:0]  w_idx;
    logic        w_elig;
    logic        w_over;
    logic [16:0] w_sum;
    logic [15:0] w_total_sat;
    logic [31:0] w_advance;
    logic        w_unused_bits;

    assign w_busy  = (r_state != S_IDLE) && (r_state != S_DONE);
    assign w_start = bus.slave_write && (bus.slave_address == 4'd0);

    // Piece decode: signed byte, generator index is |pc| - 1.
    assign w_abs   = r_pc[7] ? (~r_pc + 8'd1) : r_pc;
    assign w_absm1 = w_abs - 8'd1;
    assign w_idx   = w_absm1[2:0];
    assign w_elig  = (r_pc != 8'd0) && (r_pc[7] == r_side) && (w_abs <= c_NUM_GEN);

    assign w_over      = {16'd0, r_total} >= r_max;
    assign w_sum       = {1'b0, r_total} + {1'b0, bus.gen_readdata[15:0]};
    assign w_total_sat = w_sum[16] ? 16'hFFFF : w_sum[15:0];
    assign w_advance   = {16'd0, bus.gen_readdata[15:0]} * c_BOARD_BYTES;

    assign w_unused_bits = ^{bus.slave_read, bus.master_readdata[31:8],
                             bus.gen_readdata[31:16], w_absm1[7:3]};

    assign bus.slave_waitrequest = 1'b0;

    // CPU register read mux, combinational from the address.
    always_comb begin
        bus.slave_readdata = 32'd0;
        case (bus.slave_address)
            4'd0:    bus.slave_readdata = {w_busy, r_ovf, 14'd0, r_total};
            4'd1:    bus.slave_readdata = {16'd0, r_disp};
            default: bus.slave_readdata = 32'd0;
        endcase
    end

    // Next-state and next-square selection for the scan sequencer.
    always_comb begin
        w_nxt    = r_state;
        w_sq_nxt = r_sq;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_nxt    = S_RD_SQ;
                    w_sq_nxt = 6'd0;
                end
            end
            S_DONE: begin
                if (w_start) begin
                    w_nxt    = S_RD_SQ;
                    w_sq_nxt = 6'd0;
                end else begin
                    w_nxt = S_IDLE;
                end
            end
            S_RD_SQ:  if (!bus.master_waitrequest)  w_nxt = S_WT_SQ;
            S_WT_SQ:  if (bus.master_readdatavalid) w_nxt = S_DECIDE;
            S_DECIDE: w_nxt = w_elig ? S_WR_SRC : S_NEXT;
            S_WR_SRC: if (!bus.gen_waitrequest) w_nxt = S_WR_DST;
            S_WR_DST: if (!bus.gen_waitrequest) w_nxt = S_WR_X;
            S_WR_X:   if (!bus.gen_waitrequest) w_nxt = S_WR_Y;
            S_WR_Y:   if (!bus.gen_waitrequest) w_nxt = S_WR_GO;
            S_WR_GO:  if (!bus.gen_waitrequest) w_nxt = S_RD_CNT;
            S_RD_CNT: if (!bus.gen_waitrequest) w_nxt = S_CHK;
            S_CHK:    w_nxt = w_over ? S_DONE : S_NEXT;
            S_NEXT: begin
                if (r_sq == 6'd63) begin
                    w_nxt = S_DONE;
                end else begin
                    w_nxt    = S_RD_SQ;
                    w_sq_nxt = r_sq + 6'd1;
                end
            end
            default: w_nxt = S_IDLE;
        endcase
    end

    // Sequencer state, pass bookkeeping and registered bus outputs decoded
    // from the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state           <= S_IDLE;
            r_src             <= 32'd0;
            r_dest_base       <= 32'd0;
            r_max             <= 32'd0;
            r_side            <= 1'b0;
            r_sq              <= 6'd0;
            r_pc              <= 8'd0;
            r_total           <= 16'd0;
            r_disp            <= 16'd0;
            r_ovf             <= 1'b0;
            r_cur_dest        <= 32'd0;
            bus.master_read    <= 1'b0;
            bus.master_address <= 32'd0;
            bus.gen_write      <= 1'b0;
            bus.gen_read       <= 1'b0;
            bus.gen_address    <= 8'd0;
            bus.gen_writedata  <= 32'd0;
        end else begin
            r_state <= w_nxt;
            r_sq    <= w_sq_nxt;

            if (bus.slave_write && !w_busy) begin
                case (bus.slave_address)
                    4'd1:    r_src       <= bus.slave_writedata;
                    4'd2:    r_dest_base <= bus.slave_writedata;
                    4'd3:    r_max       <= bus.slave_writedata;
                    default: ;
                endcase
            end

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start) begin
                        r_side     <= bus.slave_writedata[0];
                        r_total    <= 16'd0;
                        r_disp     <= 16'd0;
                        r_ovf      <= 1'b0;
                        r_cur_dest <= r_dest_base;
                    end
                end
                S_WT_SQ: begin
                    if (bus.master_readdatavalid) r_pc <= bus.master_readdata[7:0];
                end
                S_RD_CNT: begin
                    if (!bus.gen_waitrequest) begin
                        r_total    <= w_total_sat;
                        r_cur_dest <= r_cur_dest + w_advance;
                        if (r_disp != 16'hFFFF) r_disp <= r_disp + 16'd1;
                    end
                end
                S_CHK: begin
                    if (w_over) r_ovf <= 1'b1;
                end
                default: ;
            endcase

            bus.master_read    <= 1'b0;
            bus.master_address <= 32'd0;
            bus.gen_write      <= 1'b0;
            bus.gen_read       <= 1'b0;
            bus.gen_address    <= 8'd0;
            bus.gen_writedata  <= 32'd0;
            case (w_nxt)
                S_RD_SQ: begin
                    bus.master_read    <= 1'b1;
                    bus.master_address <= r_src + {24'd0, w_sq_nxt, 2'b00};
                end
                S_WR_SRC: begin
                    bus.gen_write     <= 1'b1;
                    bus.gen_address   <= {1'b0, w_idx, 4'd1};
                    bus.gen_writedata <= r_src;
                end
                S_WR_DST: begin
                    bus.gen_write     <= 1'b1;
                    bus.gen_address   <= {1'b0, w_idx, 4'd2};
                    bus.gen_writedata <= r_cur_dest;
                end
                S_WR_X: begin
                    bus.gen_write     <= 1'b1;
                    bus.gen_address   <= {1'b0, w_idx, 4'd3};
                    bus.gen_writedata <= {29'd0, r_sq[2:0]};
                end
                S_WR_Y: begin
                    bus.gen_write     <= 1'b1;
                    bus.gen_address   <= {1'b0, w_idx, 4'd4};
                    bus.gen_writedata <= {29'd0, r_sq[5:3]};
                end
                S_WR_GO: begin
                    bus.gen_write     <= 1'b1;
                    bus.gen_address   <= {1'b0, w_idx, 4'd0};
                    bus.gen_writedata <= 32'd0;
                end
                S_RD_CNT: begin
                    bus.gen_read    <= 1'b1;
                    bus.gen_address <= {1'b0, w_idx, 4'd0};
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
